// File: rtl/rram_adc_readout_sequencer.sv
// ---------------------------------------------------------------------------
// rram_adc_readout_sequencer
//
// Walks the shared SL-multiplexed ADC bank of one RRAM core through a run of
// mux positions. For each position it drives the mux index, waits for the
// SL lines to settle, strobes the ADCs, converts every thermometer code to
// binary and pushes the packed result to the output FIFO as WORDS words.
//
// Ports:
//   CLK, RST       clock, synchronous active-high reset
//   start          one-cycle request, honoured only while idle
//   first_mux      first mux position of the run
//   num_mux        number of positions to read (0..SL_PER_ADC)
//   busy           high from accepted start until completion
//   done           one-cycle completion pulse
//   SL_MUX_IDX     current mux position to the SL mux decoder
//   ADC_SAMPLE     one-cycle ADC conversion strobe
//   ADCOUT_THERM   packed thermometer outputs, ADC k at [15k+14:15k]
//   push_n_oFIFO   active-low FIFO push
//   full_oFIFO     FIFO full (backpressure)
//   din_oFIFO      FIFO write word
// ---------------------------------------------------------------------------
module rram_adc_readout_sequencer #(
    parameter int NUM_ADC         = 32,
    parameter int SL_PER_ADC      = 16,
    parameter int ADC_WIDTH_THERM = 15,
    parameter int ADC_WIDTH       = 4,
    parameter int DATAOUT_WIDTH   = 64,
    parameter int SETTLE_CYCLES   = 2
) (
    input  logic                                  CLK,
    input  logic                                  RST,
    input  logic                                  start,
    input  logic [$clog2(SL_PER_ADC)-1:0]         first_mux,
    input  logic [$clog2(SL_PER_ADC):0]           num_mux,
    output logic                                  busy,
    output logic                                  done,
    output logic [$clog2(SL_PER_ADC)-1:0]         SL_MUX_IDX,
    output logic                                  ADC_SAMPLE,
    input  logic [NUM_ADC*ADC_WIDTH_THERM-1:0]    ADCOUT_THERM,
    output logic                                  push_n_oFIFO,
    input  logic                                  full_oFIFO,
    output logic [DATAOUT_WIDTH-1:0]              din_oFIFO
);

    localparam int MUX_W  = $clog2(SL_PER_ADC);
    localparam int NUM_W  = MUX_W + 1;
    localparam int BUF_W  = NUM_ADC * ADC_WIDTH;
    localparam int WORDS  = BUF_W / DATAOUT_WIDTH;
    localparam int WORD_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [WORD_W-1:0] LAST_WORD   = WORD_W'(WORDS - 1);
    localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [MUX_W-1:0]  MUX_LAST    = MUX_W'(SL_PER_ADC - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        CAPTURE,
        PUSH
    } state_t;

    state_t             state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [MUX_W-1:0]   mux_idx_q, mux_idx_d;
    logic [NUM_W-1:0]   rem_q, rem_d;
    logic [SET_W-1:0]   settle_cnt_q, settle_cnt_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic [BUF_W-1:0]   wbuf_q, wbuf_d;

    // Popcount rather than a priority encode, so a bubble in the thermometer
    // code costs at most one LSB instead of corrupting the result.
    function automatic logic [ADC_WIDTH-1:0] therm2bin(
        input logic [ADC_WIDTH_THERM-1:0] therm
    );
        logic [ADC_WIDTH-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < ADC_WIDTH_THERM; i++) begin
            cnt = cnt + ADC_WIDTH'(therm[i]);
        end
        return cnt;
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            mux_idx_q    <= '0;
            rem_q        <= '0;
            settle_cnt_q <= '0;
            word_q       <= '0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            mux_idx_q    <= mux_idx_d;
            rem_q        <= rem_d;
            settle_cnt_q <= settle_cnt_d;
            word_q       <= word_d;
        end
    end

    // Result buffer is pure data; it is only observable through din_oFIFO
    // while in PUSH, so it needs no reset.
    always_ff @(posedge CLK) begin
        wbuf_q <= wbuf_d;
    end

    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        mux_idx_d    = mux_idx_q;
        rem_d        = rem_q;
        settle_cnt_d = settle_cnt_q;
        word_d       = word_q;
        wbuf_d       = wbuf_q;
        ADC_SAMPLE   = 1'b0;
        push_n_oFIFO = 1'b1;
        din_oFIFO    = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_mux != '0) begin
                        rem_d        = num_mux;
                        mux_idx_d    = first_mux;
                        busy_d       = 1'b1;
                        settle_cnt_d = '0;
                        state_d      = SETTLE;
                    end else begin
                        // Empty request: acknowledge without touching the bank.
                        done_d = 1'b1;
                    end
                end
            end
            SETTLE: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d = SAMPLE;
                end else begin
                    settle_cnt_d = settle_cnt_q + SET_W'(1);
                end
            end
            SAMPLE: begin
                ADC_SAMPLE = 1'b1;
                state_d    = CAPTURE;
            end
            CAPTURE: begin
                for (int k = 0; k < NUM_ADC; k++) begin
                    wbuf_d[k*ADC_WIDTH +: ADC_WIDTH] =
                        therm2bin(ADCOUT_THERM[k*ADC_WIDTH_THERM +: ADC_WIDTH_THERM]);
                end
                word_d  = '0;
                state_d = PUSH;
            end
            PUSH: begin
                for (int w = 0; w < WORDS; w++) begin
                    if (word_q == WORD_W'(w)) begin
                        din_oFIFO = wbuf_q[w*DATAOUT_WIDTH +: DATAOUT_WIDTH];
                    end
                end
                // Push is gated combinationally by full so a stalled word is
                // never written twice or dropped.
                if (!full_oFIFO) begin
                    push_n_oFIFO = 1'b0;
                    if (word_q != LAST_WORD) begin
                        word_d = word_q + WORD_W'(1);
                    end else if (rem_q != NUM_W'(1)) begin
                        rem_d        = rem_q - NUM_W'(1);
                        mux_idx_d    = (mux_idx_q == MUX_LAST) ? '0 : mux_idx_q + MUX_W'(1);
                        settle_cnt_d = '0;
                        state_d      = SETTLE;
                    end else begin
                        rem_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign SL_MUX_IDX = mux_idx_q;

endmodule

// File: tb/tb_rram_adc_readout_sequencer.sv
module tb_rram_adc_readout_sequencer;

    localparam int NUM_ADC = 32;
    localparam int TW      = 15;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          start = 1'b0;
    logic [3:0]    first_mux = '0;
    logic [4:0]    num_mux = '0;
    logic          busy;
    logic          done;
    logic [3:0]    SL_MUX_IDX;
    logic          ADC_SAMPLE;
    logic [NUM_ADC*TW-1:0] ADCOUT_THERM = '0;
    logic          push_n_oFIFO;
    logic          full_oFIFO = 1'b0;
    logic [63:0]   din_oFIFO;

    int n_checks = 0;
    int n_fail   = 0;

    logic        rec_sample[64];
    logic        rec_push[64];
    logic        rec_done[64];
    logic        rec_busy[64];
    logic [3:0]  rec_idx[64];
    logic [63:0] rec_din[64];

    always #5 CLK = ~CLK;

    rram_adc_readout_sequencer dut (
        .CLK          (CLK),
        .RST          (RST),
        .start        (start),
        .first_mux    (first_mux),
        .num_mux      (num_mux),
        .busy         (busy),
        .done         (done),
        .SL_MUX_IDX   (SL_MUX_IDX),
        .ADC_SAMPLE   (ADC_SAMPLE),
        .ADCOUT_THERM (ADCOUT_THERM),
        .push_n_oFIFO (push_n_oFIFO),
        .full_oFIFO   (full_oFIFO),
        .din_oFIFO    (din_oFIFO)
    );

    task automatic set_all_therm(input logic [TW-1:0] v);
        for (int k = 0; k < NUM_ADC; k++) ADCOUT_THERM[k*TW +: TW] = v;
    endtask

    task automatic set_pack_pattern();
        ADCOUT_THERM = '0;
        ADCOUT_THERM[0*TW +: TW]  = 15'h005F;
        ADCOUT_THERM[1*TW +: TW]  = 15'h7FFF;
        ADCOUT_THERM[16*TW +: TW] = 15'h0001;
    endtask

    // Leaves the bench #1 after edge E0 (the edge that samples start).
    task automatic issue_start(input logic [3:0] f, input logic [4:0] n);
        @(posedge CLK); #1;
        first_mux = f;
        num_mux   = n;
        start     = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
    endtask

    // Records cycles 1..ncyc after E0 (sampled at negedge). full_oFIFO is
    // held high for cycles [full_from, full_from+full_len); an extra start is
    // injected in cycle xs_cyc and RST in cycle rst_cyc (0 = never).
    task automatic record(input int ncyc, input int full_from, input int full_len,
                          input int xs_cyc, input int rst_cyc);
        for (int c = 1; c <= ncyc; c++) begin
            if (c > 1) begin
                @(posedge CLK); #1;
            end
            full_oFIFO = (full_len > 0) && (c >= full_from) && (c < full_from + full_len);
            start      = (c == xs_cyc);
            if (c == xs_cyc) begin
                first_mux = 4'd9;
                num_mux   = 5'd2;
            end
            RST = (c == rst_cyc);
            @(negedge CLK);
            rec_sample[c] = ADC_SAMPLE;
            rec_push[c]   = !push_n_oFIFO;
            rec_done[c]   = done;
            rec_busy[c]   = busy;
            rec_idx[c]    = SL_MUX_IDX;
            rec_din[c]    = din_oFIFO;
        end
        @(posedge CLK); #1;
        full_oFIFO = 1'b0;
        start      = 1'b0;
        RST        = 1'b0;
    endtask

    function automatic int cnt_push(input int lo, input int hi);
        int n = 0;
        for (int c = lo; c <= hi; c++) if (rec_push[c]) n++;
        return n;
    endfunction

    function automatic int cnt_sample(input int ncyc);
        int n = 0;
        for (int c = 1; c <= ncyc; c++) if (rec_sample[c]) n++;
        return n;
    endfunction

    function automatic int cnt_done(input int ncyc);
        int n = 0;
        for (int c = 1; c <= ncyc; c++) if (rec_done[c]) n++;
        return n;
    endfunction

    task automatic test_reset();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (SL_MUX_IDX !== 4'd0) begin n_fail++; $display("FAIL reset_idx: got %0d want 0", SL_MUX_IDX); end
        n_checks++; if (ADC_SAMPLE !== 1'b0) begin n_fail++; $display("FAIL reset_sample: got %b want 0", ADC_SAMPLE); end
        n_checks++; if (push_n_oFIFO !== 1'b1) begin n_fail++; $display("FAIL reset_push_n: got %b want 1", push_n_oFIFO); end
        n_checks++; if (din_oFIFO !== 64'd0) begin n_fail++; $display("FAIL reset_din: got %h want 0", din_oFIFO); end
        @(posedge CLK); #1;
        RST = 1'b0;
    endtask

    task automatic test_single();
        set_all_therm(15'h00FF);
        issue_start(4'd3, 5'd1);
        record(12, 0, 0, 0, 0);
        n_checks++; if (rec_idx[1] !== 4'd3) begin n_fail++; $display("FAIL single_idx: got %0d want 3", rec_idx[1]); end
        n_checks++; if (rec_busy[1] !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", rec_busy[1]); end
        n_checks++; if (rec_sample[3] !== 1'b1 || cnt_sample(12) != 1) begin n_fail++; $display("FAIL single_sample: got c3=%b count=%0d want 1/1", rec_sample[3], cnt_sample(12)); end
        n_checks++; if (rec_push[5] !== 1'b1 || rec_push[6] !== 1'b1 || cnt_push(1, 12) != 2) begin n_fail++; $display("FAIL single_push: got c5=%b c6=%b count=%0d want 1/1/2", rec_push[5], rec_push[6], cnt_push(1, 12)); end
        n_checks++; if (rec_din[5] !== 64'h8888_8888_8888_8888) begin n_fail++; $display("FAIL single_word0: got %h want 8888888888888888", rec_din[5]); end
        n_checks++; if (rec_din[6] !== 64'h8888_8888_8888_8888) begin n_fail++; $display("FAIL single_word1: got %h want 8888888888888888", rec_din[6]); end
        n_checks++; if (rec_done[7] !== 1'b1 || cnt_done(12) != 1) begin n_fail++; $display("FAIL single_done: got c7=%b count=%0d want 1/1", rec_done[7], cnt_done(12)); end
        n_checks++; if (rec_busy[7] !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b want 0", rec_busy[7]); end
    endtask

    task automatic test_packing();
        set_pack_pattern();
        issue_start(4'd0, 5'd1);
        record(10, 0, 0, 0, 0);
        n_checks++; if (rec_din[5] !== 64'h0000_0000_0000_00F6) begin n_fail++; $display("FAIL pack_word0: got %h want 00000000000000f6", rec_din[5]); end
        n_checks++; if (rec_din[6] !== 64'h0000_0000_0000_0001) begin n_fail++; $display("FAIL pack_word1: got %h want 0000000000000001", rec_din[6]); end
    endtask

    task automatic test_wrap();
        logic [3:0] exp_idx[4];
        exp_idx[0] = 4'd14; exp_idx[1] = 4'd15; exp_idx[2] = 4'd0; exp_idx[3] = 4'd1;
        set_all_therm(15'h0007);
        issue_start(4'd14, 5'd4);
        record(30, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rec_sample[3+6*i] !== 1'b1 || rec_idx[3+6*i] !== exp_idx[i]) begin
                n_fail++;
                $display("FAIL wrap_pos%0d: got sample=%b idx=%0d want 1/%0d", i, rec_sample[3+6*i], rec_idx[3+6*i], exp_idx[i]);
            end
        end
        n_checks++; if (cnt_sample(30) != 4) begin n_fail++; $display("FAIL wrap_samples: got %0d want 4", cnt_sample(30)); end
        n_checks++; if (cnt_push(1, 30) != 8) begin n_fail++; $display("FAIL wrap_pushes: got %0d want 8", cnt_push(1, 30)); end
        n_checks++; if (rec_done[25] !== 1'b1 || cnt_done(30) != 1) begin n_fail++; $display("FAIL wrap_done: got c25=%b count=%0d want 1/1", rec_done[25], cnt_done(30)); end
        n_checks++; if (rec_din[24] !== 64'h3333_3333_3333_3333) begin n_fail++; $display("FAIL wrap_last_word: got %h want 3333333333333333", rec_din[24]); end
    endtask

    task automatic test_backpressure();
        set_pack_pattern();
        issue_start(4'd2, 5'd1);
        record(16, 5, 5, 0, 0);
        n_checks++; if (cnt_push(5, 9) != 0) begin n_fail++; $display("FAIL bp_no_push: got %0d pushes while full want 0", cnt_push(5, 9)); end
        for (int c = 5; c <= 9; c++) begin
            n_checks++;
            if (rec_din[c] !== 64'h0000_0000_0000_00F6) begin n_fail++; $display("FAIL bp_din_stable c%0d: got %h want 00000000000000f6", c, rec_din[c]); end
        end
        n_checks++; if (rec_push[10] !== 1'b1 || rec_din[10] !== 64'h0000_0000_0000_00F6) begin n_fail++; $display("FAIL bp_word0: got push=%b din=%h want 1/00000000000000f6", rec_push[10], rec_din[10]); end
        n_checks++; if (rec_push[11] !== 1'b1 || rec_din[11] !== 64'h0000_0000_0000_0001) begin n_fail++; $display("FAIL bp_word1: got push=%b din=%h want 1/0000000000000001", rec_push[11], rec_din[11]); end
        n_checks++; if (rec_done[12] !== 1'b1 || cnt_done(16) != 1) begin n_fail++; $display("FAIL bp_done: got c12=%b count=%0d want 1/1", rec_done[12], cnt_done(16)); end
    endtask

    task automatic test_back_to_back();
        set_all_therm(15'h00FF);
        issue_start(4'd3, 5'd1);
        record(20, 0, 0, 2, 0);
        n_checks++; if (rec_done[7] !== 1'b1 || cnt_done(20) != 1) begin n_fail++; $display("FAIL busy_start_done: got c7=%b count=%0d want 1/1", rec_done[7], cnt_done(20)); end
        n_checks++; if (cnt_sample(20) != 1 || cnt_push(1, 20) != 2) begin n_fail++; $display("FAIL busy_start_reads: got samples=%0d pushes=%0d want 1/2", cnt_sample(20), cnt_push(1, 20)); end
        n_checks++; if (rec_idx[20] !== 4'd3) begin n_fail++; $display("FAIL busy_start_idx: got %0d want 3", rec_idx[20]); end
    endtask

    task automatic test_zero();
        issue_start(4'd5, 5'd0);
        record(8, 0, 0, 0, 0);
        n_checks++; if (rec_done[1] !== 1'b1 || cnt_done(8) != 1) begin n_fail++; $display("FAIL zero_done: got c1=%b count=%0d want 1/1", rec_done[1], cnt_done(8)); end
        n_checks++; if (rec_busy[1] !== 1'b0) begin n_fail++; $display("FAIL zero_busy: got %b want 0", rec_busy[1]); end
        n_checks++; if (cnt_sample(8) != 0 || cnt_push(1, 8) != 0) begin n_fail++; $display("FAIL zero_activity: got samples=%0d pushes=%0d want 0/0", cnt_sample(8), cnt_push(1, 8)); end
    endtask

    task automatic test_rst_mid();
        set_all_therm(15'h00FF);
        issue_start(4'd3, 5'd2);
        record(14, 0, 0, 0, 6);
        n_checks++; if (rec_busy[7] !== 1'b0 || rec_idx[7] !== 4'd0) begin n_fail++; $display("FAIL rst_ctrl: got busy=%b idx=%0d want 0/0", rec_busy[7], rec_idx[7]); end
        n_checks++; if (rec_push[7] !== 1'b0 || rec_din[7] !== 64'd0) begin n_fail++; $display("FAIL rst_out: got push=%b din=%h want 0/0", rec_push[7], rec_din[7]); end
        n_checks++; if (cnt_push(1, 14) != 2 || cnt_sample(14) != 1 || cnt_done(14) != 0) begin n_fail++; $display("FAIL rst_activity: got pushes=%0d samples=%0d dones=%0d want 2/1/0", cnt_push(1, 14), cnt_sample(14), cnt_done(14)); end
        set_all_therm(15'h0003);
        issue_start(4'd5, 5'd1);
        record(10, 0, 0, 0, 0);
        n_checks++; if (rec_idx[1] !== 4'd5 || rec_done[7] !== 1'b1 || cnt_done(10) != 1) begin n_fail++; $display("FAIL rst_restart: got idx=%0d done7=%b count=%0d want 5/1/1", rec_idx[1], rec_done[7], cnt_done(10)); end
        n_checks++; if (rec_din[5] !== 64'h2222_2222_2222_2222 || cnt_push(1, 10) != 2) begin n_fail++; $display("FAIL rst_restart_data: got din=%h pushes=%0d want 2222222222222222/2", rec_din[5], cnt_push(1, 10)); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_packing();
        test_wrap();
        test_backpressure();
        test_back_to_back();
        test_zero();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rram_adc_readout_sequencer.md
# rram_adc_readout_sequencer

Sequences the shared SL-multiplexed ADC bank of one RRAM core during a read/MAC operation. For each selected SL mux position, it:
- drives the mux index,
- waits for settling,
- strobes the ADCs,
- converts the thermometer outputs to binary,
- packs the results into output-FIFO words.

It sits between `rram_controller_fsm`, which issues a start after WL/BL/SL biasing, and the output data FIFO. It owns `SL_MUX_SEL` sequencing and `push_n_oFIFO` for read results.

## Interface
Parameters:
- NUM_ADC, 32, ADCs in the bank
- SL_PER_ADC, 16, SLs sharing one ADC through the mux
- ADC_WIDTH_THERM, 15, thermometer bits per ADC
- ADC_WIDTH, 4, binary bits per ADC
- DATAOUT_WIDTH, 64, output FIFO word width; NUM_ADC*ADC_WIDTH must be a multiple of it
- SETTLE_CYCLES, 2, cycles between mux change and sample strobe (≥1)

Ports:
- CLK  in  1  single clock
- RST  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; honoured only in IDLE
- first_mux  in  $clog2(SL_PER_ADC)  first mux position
- num_mux  in  $clog2(SL_PER_ADC)+1  positions to read (0..SL_PER_ADC)
- busy  out  1  high from accepted start until completion
- done  out  1  one-cycle completion pulse
- SL_MUX_IDX  out  $clog2(SL_PER_ADC)  current mux position to the SL mux decoder
- ADC_SAMPLE  out  1  one-cycle ADC conversion strobe
- ADCOUT_THERM  in  NUM_ADC*ADC_WIDTH_THERM  packed thermometer outputs; ADC k is at bits [15k+14:15k]
- push_n_oFIFO  out  1  active-low push
- full_oFIFO  in  1  output FIFO full
- din_oFIFO  out  DATAOUT_WIDTH  output word

## Operation
- States:
  - IDLE
  - SETTLE
  - SAMPLE
  - CAPTURE
  - PUSH
- WORDS = NUM_ADC*ADC_WIDTH/DATAOUT_WIDTH, which is 2 at the default parameters.
- IDLE:
  - start=1 with num_mux≠0: latch num_mux; set SL_MUX_IDX←first_mux, busy←1, settle counter←0; go to SETTLE.
  - start=1 with num_mux=0: done←1 next cycle; busy stays 0; no strobe; no push.
- SETTLE: counts SETTLE_CYCLES cycles, then goes to SAMPLE.
- SAMPLE: ADC_SAMPLE=1 for exactly this cycle; then go to CAPTURE.
- CAPTURE:
  - Register all NUM_ADC conversions into the word buffer at the end of this cycle.
  - Conversion is popcount of the 15 thermometer bits (bubble-tolerant), giving 0..15.
  - Binary value of ADC k goes to buffer bits [4k+3:4k]. Word w = buffer bits [64w+63:64w]; word 0 carries ADCs 0..15.
  - Then go to PUSH with w=0.
- PUSH:
  - din_oFIFO = word w.
  - push_n_oFIFO = !(state==PUSH && !full_oFIFO). This is combinational on full_oFIFO, so no push is issued while full.
  - When full_oFIFO=1: stall with din_oFIFO held stable.
  - On a push with w<WORDS-1: w←w+1.
  - On a push with w=WORDS-1 and positions remaining: SL_MUX_IDX←(SL_MUX_IDX+1) mod SL_PER_ADC (wraps), then SETTLE.
  - On a push with w=WORDS-1 and no positions remaining: IDLE; busy←0 and done←1 on the same edge.
- start while busy is ignored; it is not queued.
- RST at any time:
  - All outputs take their reset values next edge; state←IDLE.
  - The partially read position is discarded; no further pushes.
- Reset values:
  - busy=0
  - done=0
  - SL_MUX_IDX=0
  - ADC_SAMPLE=0
  - push_n_oFIFO=1
  - din_oFIFO=0

## Timing
- start sampled at edge E0; SL_MUX_IDX valid from E0+1.
- SETTLE occupies cycles E0+1..E0+SETTLE_CYCLES.
- ADC_SAMPLE is high in cycle E0+SETTLE_CYCLES+1.
- ADCOUT_THERM must be valid in the cycle after ADC_SAMPLE (CAPTURE) and is sampled at its end.
- Without backpressure, each position costs SETTLE_CYCLES+2+WORDS cycles (6 at the defaults).
- The next position's SETTLE starts the cycle after its last push.
- done is high in the cycle after the final push; busy falls at that same edge.
- Each cycle with full_oFIFO=1 in PUSH adds one cycle; there is no other latency variation.
- At most one push per cycle.

## Test plan
- Single position, defaults: first_mux=3, num_mux=1, all ADCs drive 15'h00FF.
  - SL_MUX_IDX=3.
  - ADC_SAMPLE in cycle 3 after start.
  - Pushes in cycles 5 and 6, both with din_oFIFO=64'h8888_8888_8888_8888.
  - done in cycle 7.
- Bubble/packing: ADC0=15'h005F, ADC1=15'h7FFF, ADC16=15'h0001, all others 0.
  - Word0 = 64'h0000_0000_0000_00F6.
  - Word1 = 64'h0000_0000_0000_0001.
- Wrap-around: first_mux=14, num_mux=4.
  - SL_MUX_IDX sequence is 14, 15, 0, 1.
  - 4 ADC_SAMPLE strobes, 8 pushes.
  - Total 24 cycles to done.
- Backpressure: full_oFIFO=1 for 5 cycles when entering PUSH.
  - push_n_oFIFO stays 1 and din_oFIFO is stable throughout.
  - Word0 is pushed in the first cycle full drops.
  - done is delayed by exactly 5 cycles.
- start pulse at cycle 2 while busy: ignored.
  - Exactly one done, and only the original positions are read.
- num_mux=0: done the next cycle; busy, ADC_SAMPLE and push_n_oFIFO are untouched.
- RST asserted during the second PUSH cycle:
  - Next edge: state IDLE, all outputs at reset values, no further pushes.
  - A fresh start then completes normally.
